// File: rtl/w_wb_queue_pkg.sv
// rtl/w_wb_queue_pkg.sv - shared entry record and default depth for the write-back queue
package w_wb_queue_pkg;

  localparam int WBQ_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc8;
  } wbq_entry_t;

endpackage

// File: rtl/w_wb_queue_if.sv
// rtl/w_wb_queue_if.sv - request, register-file write and forwarding signals of the write-back queue
interface w_wb_queue_if;

  logic        P_RegWrite;
  logic [4:0]  P_A3;
  logic [31:0] P_WD;
  logic [31:0] P_PC8;
  logic        P_Ready;

  logic        L_RegWrite;
  logic [4:0]  L_A3;
  logic [31:0] L_WD;
  logic [31:0] L_PC8;
  logic        L_Ready;

  logic        W_RegWrite;
  logic [4:0]  W_A3;
  logic [31:0] W_RegWriteData;
  logic [31:0] W_PC8;
  logic        Busy;

  logic [4:0]  F_A1;
  logic [4:0]  F_A2;
  logic        F_Hit1;
  logic        F_Hit2;
  logic [31:0] F_V1;
  logic [31:0] F_V2;

  modport master (
    output P_RegWrite, P_A3, P_WD, P_PC8, L_RegWrite, L_A3, L_WD, L_PC8, F_A1, F_A2,
    input  P_Ready, L_Ready, W_RegWrite, W_A3, W_RegWriteData, W_PC8, Busy,
    input  F_Hit1, F_Hit2, F_V1, F_V2
  );

  modport slave (
    input  P_RegWrite, P_A3, P_WD, P_PC8, L_RegWrite, L_A3, L_WD, L_PC8, F_A1, F_A2,
    output P_Ready, L_Ready, W_RegWrite, W_A3, W_RegWriteData, W_PC8, Busy,
    output F_Hit1, F_Hit2, F_V1, F_V2
  );

endinterface

// File: rtl/w_wb_queue_lookup.sv
// rtl/w_wb_queue_lookup.sv - newest-match search over the queued entries for one forwarding port
module wbq_lookup
  import w_wb_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH_DEFAULT,
  parameter int PW    = $clog2(DEPTH)
) (
  input  wbq_entry_t  entries_i [DEPTH],
  input  logic [PW-1:0] head_i,
  input  logic [PW:0]   count_i,
  input  logic [4:0]    addr_i,
  output logic          hit_o,
  output logic [31:0]   value_o
);

  logic [PW-1:0] idx;

  // Walk oldest to newest so the last match overwrites earlier ones.
  always_comb begin
    hit_o   = 1'b0;
    value_o = '0;
    idx     = head_i;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if (((PW+1)'(i) < count_i) && (addr_i != 5'd0) && (entries_i[idx].a3 == addr_i)) begin
        hit_o   = 1'b1;
        value_o = entries_i[idx].wd;
      end
    end
  end

endmodule

// File: rtl/w_wb_queue.sv
// rtl/w_wb_queue.sv - two-source register write-back FIFO feeding a single register-file write port
// Forwarding lookup is compiled in when WB_QUEUE_FWD_EN is defined.
module w_wb_queue
  import w_wb_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH_DEFAULT
) (
  input logic         clk,
  input logic         reset,
  w_wb_queue_if.slave wb
);

  localparam int PW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("w_wb_queue: DEPTH must be a power of two and at least 2");
  end

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  wbq_entry_t    mem_q [DEPTH];

  logic          p_ready, l_ready, p_enq, l_enq, deq;
  logic [PW-1:0] p_slot, l_slot;
  wbq_entry_t    head_e;

  // Readiness comes from registered count only; zero-destination requests are accepted then dropped.
  assign p_ready = (count_q <= (PW+1)'(DEPTH - 1));
  assign l_ready = (count_q <= (PW+1)'(DEPTH - 2));
  assign p_enq   = wb.P_RegWrite && p_ready && (wb.P_A3 != 5'd0);
  assign l_enq   = wb.L_RegWrite && l_ready && (wb.L_A3 != 5'd0);
  assign deq     = (count_q != '0);

  assign p_slot  = tail_q;
  assign l_slot  = p_enq ? (tail_q + PW'(1)) : tail_q;

  always_comb begin
    head_d  = head_q + PW'(deq);
    tail_d  = tail_q + PW'(p_enq) + PW'(l_enq);
    count_d = count_q + (PW+1)'(p_enq) + (PW+1)'(l_enq) - (PW+1)'(deq);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is left uncleared; count and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (p_enq) mem_q[p_slot] <= '{a3: wb.P_A3, wd: wb.P_WD, pc8: wb.P_PC8};
      if (l_enq) mem_q[l_slot] <= '{a3: wb.L_A3, wd: wb.L_WD, pc8: wb.L_PC8};
    end
  end

  assign head_e            = mem_q[head_q];
  assign wb.P_Ready        = p_ready;
  assign wb.L_Ready        = l_ready;
  assign wb.W_RegWrite     = deq;
  assign wb.W_A3           = deq ? head_e.a3  : 5'd0;
  assign wb.W_RegWriteData = deq ? head_e.wd  : 32'd0;
  assign wb.W_PC8          = deq ? head_e.pc8 : 32'd0;
  assign wb.Busy           = deq;

`ifdef WB_QUEUE_FWD_EN
  wbq_lookup #(.DEPTH(DEPTH), .PW(PW)) u_lookup1 (
    .entries_i (mem_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .addr_i    (wb.F_A1),
    .hit_o     (wb.F_Hit1),
    .value_o   (wb.F_V1)
  );

  wbq_lookup #(.DEPTH(DEPTH), .PW(PW)) u_lookup2 (
    .entries_i (mem_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .addr_i    (wb.F_A2),
    .hit_o     (wb.F_Hit2),
    .value_o   (wb.F_V2)
  );
`else
  logic unused_faddr;
  assign unused_faddr = ^{wb.F_A1, wb.F_A2};
  assign wb.F_Hit1    = 1'b0;
  assign wb.F_Hit2    = 1'b0;
  assign wb.F_V1      = 32'd0;
  assign wb.F_V2      = 32'd0;
`endif

endmodule

// File: tb/tb_w_wb_queue.sv
// tb/tb_w_wb_queue.sv - directed vector table plus a scoreboarded traffic sequence for w_wb_queue
module tb_w_wb_queue;
  import w_wb_queue_pkg::*;

`ifdef WB_QUEUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic        rn, pv, lv;
    logic [4:0]  pa3, la3, fa1, fa2;
    logic [31:0] pwd, ppc, lwd, lpc;
    logic        epr, elr, ewv, eh1, eh2;
    logic [4:0]  ewa3;
    logic [31:0] ewwd, ewpc, ev1, ev2;
  } vec_t;

  logic clk;
  logic reset;
  w_wb_queue_if wb ();

  w_wb_queue #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .wb(wb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int row    = 0;
  vec_t vq[$];
  wbq_entry_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h expected %h", name, row, act, exp);
    end
  endtask

  function automatic void add(
    input logic rn, input logic pv, input logic [4:0] pa3, input logic [31:0] pwd, input logic [31:0] ppc,
    input logic lv, input logic [4:0] la3, input logic [31:0] lwd, input logic [31:0] lpc,
    input logic [4:0] fa1, input logic [4:0] fa2, input logic epr, input logic elr,
    input logic ewv, input logic [4:0] ewa3, input logic [31:0] ewwd, input logic [31:0] ewpc,
    input logic eh1, input logic [31:0] ev1, input logic eh2, input logic [31:0] ev2);
    vec_t v;
    v.rn = rn; v.pv = pv; v.pa3 = pa3; v.pwd = pwd; v.ppc = ppc;
    v.lv = lv; v.la3 = la3; v.lwd = lwd; v.lpc = lpc; v.fa1 = fa1; v.fa2 = fa2;
    v.epr = epr; v.elr = elr; v.ewv = ewv; v.ewa3 = ewa3; v.ewwd = ewwd; v.ewpc = ewpc;
    v.eh1 = eh1; v.ev1 = ev1; v.eh2 = eh2; v.ev2 = ev2;
    vq.push_back(v);
  endfunction

  task automatic drive(input logic pv, input logic [4:0] pa3, input logic [31:0] pwd, input logic [31:0] ppc,
                       input logic lv, input logic [4:0] la3, input logic [31:0] lwd, input logic [31:0] lpc);
    wb.P_RegWrite = pv; wb.P_A3 = pa3; wb.P_WD = pwd; wb.P_PC8 = ppc;
    wb.L_RegWrite = lv; wb.L_A3 = la3; wb.L_WD = lwd; wb.L_PC8 = lpc;
  endtask

  initial begin
    // Expected outputs are those seen during the row's cycle, before its clock edge.
    add(1, 0,  0, 0,      0,       0,  0, 0,    0,     0, 0, 1, 1, 0,  0, 0,       0,       0, 0,     0, 0);
    add(1, 1,  5, 'h1234, 'h3008,  0,  0, 0,    0,     0, 0, 1, 1, 0,  0, 0,       0,       0, 0,     0, 0);
    add(1, 0,  0, 0,      0,       0,  0, 0,    0,     0, 0, 1, 1, 1,  5, 'h1234,  'h3008,  0, 0,     0, 0);
    add(1, 0,  0, 0,      0,       0,  0, 0,    0,     0, 0, 1, 1, 0,  0, 0,       0,       0, 0,     0, 0);
    add(1, 1,  3, 'hA,    'h100,   1,  3, 'hB,  'h200, 0, 0, 1, 1, 0,  0, 0,       0,       0, 0,     0, 0);
    add(1, 0,  0, 0,      0,       0,  0, 0,    0,     0, 0, 1, 1, 1,  3, 'hA,     'h100,   0, 0,     0, 0);
    add(1, 0,  0, 0,      0,       0,  0, 0,    0,     0, 0, 1, 1, 1,  3, 'hB,     'h200,   0, 0,     0, 0);
    add(1, 0,  0, 0,      0,       0,  0, 0,    0,     0, 0, 1, 1, 0,  0, 0,       0,       0, 0,     0, 0);
    add(1, 1,  0, 'hFFFF, 0,       0,  0, 0,    0,     0, 0, 1, 1, 0,  0, 0,       0,       0, 0,     0, 0);
    add(1, 0,  0, 0,      0,       0,  0, 0,    0,     0, 0, 1, 1, 0,  0, 0,       0,       0, 0,     0, 0);
    add(1, 1,  7, 'h11,   'h10,    1,  7, 'h22, 'h20,  7, 0, 1, 1, 0,  0, 0,       0,       0, 0,     0, 0);
    add(1, 0,  0, 0,      0,       0,  0, 0,    0,     7, 0, 1, 1, 1,  7, 'h11,    'h10,    1, 'h22,  0, 0);
    add(1, 0,  0, 0,      0,       0,  0, 0,    0,     0, 7, 1, 1, 1,  7, 'h22,    'h20,    0, 0,     1, 'h22);
    add(1, 0,  0, 0,      0,       0,  0, 0,    0,     7, 7, 1, 1, 0,  0, 0,       0,       0, 0,     0, 0);
    add(1, 1,  1, 1,      'h101,   1,  2, 2,    'h102, 0, 0, 1, 1, 0,  0, 0,       0,       0, 0,     0, 0);
    add(1, 1,  4, 4,      'h104,   1,  6, 6,    'h106, 0, 0, 1, 1, 1,  1, 1,       'h101,   0, 0,     0, 0);
    add(1, 0,  0, 0,      0,       1,  8, 8,    'h108, 0, 0, 1, 0, 1,  2, 2,       'h102,   0, 0,     0, 0);
    add(1, 0,  0, 0,      0,       1,  8, 8,    'h108, 0, 0, 1, 1, 1,  4, 4,       'h104,   0, 0,     0, 0);
    add(1, 0,  0, 0,      0,       0,  0, 0,    0,     0, 0, 1, 1, 1,  6, 6,       'h106,   0, 0,     0, 0);
    add(1, 0,  0, 0,      0,       0,  0, 0,    0,     0, 0, 1, 1, 1,  8, 8,       'h108,   0, 0,     0, 0);
    add(1, 0,  0, 0,      0,       0,  0, 0,    0,     0, 0, 1, 1, 0,  0, 0,       0,       0, 0,     0, 0);
    add(1, 1,  9, 9,      'h109,   1, 10, 10,   'h10a, 0, 0, 1, 1, 0,  0, 0,       0,       0, 0,     0, 0);
    add(1, 1, 11, 11,     'h10b,   1, 12, 12,   'h10c, 0, 0, 1, 1, 1,  9, 9,       'h109,   0, 0,     0, 0);
    add(0, 1, 13, 13,     'h10d,   0,  0, 0,    0,     0, 0, 1, 0, 1, 10, 10,      'h10a,   0, 0,     0, 0);
    add(1, 0,  0, 0,      0,       0,  0, 0,    0,     0, 0, 1, 1, 0,  0, 0,       0,       0, 0,     0, 0);
    add(1, 0,  0, 0,      0,       0,  0, 0,    0,     0, 0, 1, 1, 0,  0, 0,       0,       0, 0,     0, 0);

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    wb.F_A1 = 0; wb.F_A2 = 0;
    repeat (2) @(posedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      row   = i;
      reset = vq[i].rn;
      drive(vq[i].pv, vq[i].pa3, vq[i].pwd, vq[i].ppc, vq[i].lv, vq[i].la3, vq[i].lwd, vq[i].lpc);
      wb.F_A1 = vq[i].fa1; wb.F_A2 = vq[i].fa2;
      #1;
      chk("p_ready", wb.P_Ready, vq[i].epr);
      chk("l_ready", wb.L_Ready, vq[i].elr);
      chk("w_regwrite", wb.W_RegWrite, vq[i].ewv);
      chk("w_a3", wb.W_A3, vq[i].ewa3);
      chk("w_data", wb.W_RegWriteData, vq[i].ewwd);
      chk("w_pc8", wb.W_PC8, vq[i].ewpc);
      chk("busy", wb.Busy, vq[i].ewv);
      chk("f_hit1", wb.F_Hit1, FWD & vq[i].eh1);
      chk("f_v1", wb.F_V1, FWD ? vq[i].ev1 : 32'd0);
      chk("f_hit2", wb.F_Hit2, FWD & vq[i].eh2);
      chk("f_v2", wb.F_V2, FWD ? vq[i].ev2 : 32'd0);
    end

    // Continuous two-source traffic with a held long-latency request, checked against an order model.
    begin
      logic        pv, lv, lhold, p_acc, l_acc;
      logic [4:0]  pa3, la3;
      logic [31:0] pwd, lwd;
      int          mcount;
      wbq_entry_t  e;
      lhold = 1'b0; lv = 1'b0; la3 = 0; lwd = 0;
      wb.F_A1 = 0; wb.F_A2 = 0;
      for (int c = 0; c < 24; c++) begin
        @(negedge clk);
        row = 100 + c;
        pv  = (c < 12);
        pa3 = 5'(c % 4);
        pwd = 32'(c * 16 + 1);
        if (!lhold) begin
          lv  = (c < 12);
          la3 = 5'((c % 3) + 1);
          lwd = 32'(c * 16 + 2);
        end
        drive(pv, pa3, pwd, pwd + 32'h40, lv, la3, lwd, lwd + 32'h80);
        #1;
        mcount = mq.size();
        chk("seq_p_ready", wb.P_Ready, 32'(mcount <= 3));
        chk("seq_l_ready", wb.L_Ready, 32'(mcount <= 2));
        chk("seq_busy", wb.Busy, 32'(mcount != 0));
        if (mcount != 0) begin
          e = mq.pop_front();
          chk("seq_w_a3", wb.W_A3, 32'(e.a3));
          chk("seq_w_data", wb.W_RegWriteData, e.wd);
          chk("seq_w_pc8", wb.W_PC8, e.pc8);
        end else begin
          chk("seq_w_idle", wb.W_RegWrite, 0);
        end
        p_acc = pv && (mcount <= 3);
        l_acc = lv && (mcount <= 2);
        if (p_acc && pa3 != 0) mq.push_back('{a3: pa3, wd: pwd, pc8: pwd + 32'h40});
        if (l_acc && la3 != 0) mq.push_back('{a3: la3, wd: lwd, pc8: lwd + 32'h80});
        lhold = lv && !l_acc;
      end
      chk("seq_drained", 32'(mq.size()), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/w_wb_queue.md
W_WB_QUEUE -- requirements
Module: w_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, shall set the queued write entries; it shall be a power of two, at least 2.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
REQ-004 P_RegWrite / P_A3 / P_WD / P_PC8  in  1/5/32/32  pipeline write request: valid, dest reg, data, PC+8.
REQ-005 P_Ready  out  1  pipeline request accepted this cycle when P_RegWrite=1.
REQ-006 L_RegWrite / L_A3 / L_WD / L_PC8  in  1/5/32/32  long-latency (MDU) write request.
REQ-007 L_Ready  out  1  long-latency request accepted this cycle when L_RegWrite=1.
REQ-008 W_RegWrite / W_A3 / W_RegWriteData / W_PC8  out  1/5/32/32  single write port driving the register file.
REQ-009 Busy  out  1  one or more entries queued.
REQ-010 F_A1, F_A2  in  5/5  forwarding lookup addresses; F_Hit1/F_Hit2 out 1; F_V1/F_V2 out 32.

Function
REQ-011 Entries shall be held in a circular FIFO (head pointer, tail pointer, count 0..DEPTH).
REQ-012 P_Ready shall be 1 iff count <= DEPTH-1; L_Ready shall be 1 iff count <= DEPTH-2, both from registered count only.
REQ-013 A request is accepted when valid and ready; an unaccepted source holds its request unchanged until accepted.
REQ-014 Requests with A3=0 shall be accepted (ready rules unchanged) and discarded, never enqueued.
REQ-015 Same-cycle accepts from both sources shall enqueue the pipeline entry first (older), then the long-latency entry.
REQ-016 Outputs W_* shall present the head entry combinationally when count>0; when count=0, all W_* shall be 0.
REQ-017 Head shall dequeue every cycle count>0 (register file always accepts); minimum request-to-W_RegWrite latency is 1 cycle.
REQ-018 Next count shall equal count + enqueued (0..2) - dequeued (0..1); pointers shall wrap modulo DEPTH.
REQ-019 Write order to any register shall equal acceptance order; no reordering or merging.
REQ-020 Busy shall equal (count != 0).
REQ-021 F_HitN shall be 1 iff some queued entry, head included, has A3 = F_AN and F_AN != 0; F_VN shall be the newest such entry's data, else 0.

Reset
REQ-022 On reset=0 at a clock edge: count, head, tail shall become 0; W_* and Busy shall read 0 from the next cycle.
REQ-023 Reset mid-operation shall discard all queued entries and ignore same-cycle requests; no partial write shall be issued.
REQ-024 Entry storage need not be cleared; only count/pointers are reset.

Configuration
REQ-025 Macro WB_QUEUE_FWD_EN defined: forwarding lookup of REQ-021 compiled in.
REQ-026 Macro undefined: F_Hit1/F_Hit2 tied 0, F_V1/F_V2 tied 0, no lookup logic; all other behaviour unchanged.

Structure
REQ-027 Shared package shall hold the entry record typedef (a3, wd, pc8) and WBQ_DEPTH_DEFAULT constant.
REQ-028 One sub-module wbq_lookup shall implement the newest-match search and shall be instantiated twice, only under WB_QUEUE_FWD_EN.

Verification
REQ-029 Reset, then P write a3=5 wd=0x1234 pc8=0x3008 -> next cycle W_RegWrite=1, W_A3=5, W_RegWriteData=0x1234, W_PC8=0x3008; following cycle all W_*=0.
REQ-030 Same cycle P(a3=3,0xA) and L(a3=3,0xB) -> two consecutive writes to reg 3, 0xA then 0xB; Busy high 2 cycles.
REQ-031 Hold L_RegWrite with count=3 (DEPTH=4) -> L_Ready=0, P_Ready=1; L accepted once count <=2; no entry lost.
REQ-032 P write a3=0 wd=0xFFFF -> P_Ready=1, no W_RegWrite pulse, Busy stays 0.
REQ-033 WB_QUEUE_FWD_EN set, queue holds reg 7 = 0x11 then 0x22, F_A1=7 -> F_Hit1=1, F_V1=0x22; F_A2=0 -> F_Hit2=0.
REQ-034 Fill 3 entries, assert reset=0 one cycle with a P request -> count=0, no further W_RegWrite, P request not written.
